// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and scheduler state encoding for the frame scheduler slice.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_MAX     = 799;
    localparam int V_DISPLAY = 480;
    localparam int V_MAX     = 524;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } sched_state_t;

    // Index counter must also hold NUM_REQ itself, the past-the-end scan position.
    function automatic int idx_width(input int num_req);
        return (num_req < 1) ? 1 : $clog2(num_req + 1);
    endfunction

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Requester handshake bundle: level requests, done pulses, one-hot grant and watchdog flags.
interface vga_frame_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] timeout;

    modport master (output req, output done, input grant, input timeout);
    modport slave  (input req, input done, output grant, output timeout);
endinterface

// File: rtl/vga_frame_events.sv
// Purely combinational decode of the per-frame vblank-start and frame-start events.
module vga_frame_events #(
    parameter int V_DISPLAY = 480
) (
    input  logic       p_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       vblank_start,
    output logic       frame_start
);
    localparam logic [9:0] VBLANK_LINE = 10'(V_DISPLAY);

    assign vblank_start = p_tick && (x == 10'd0) && (y == VBLANK_LINE);
    assign frame_start  = p_tick && (x == 10'd0) && (y == 10'd0);
endmodule

// File: rtl/vga_frame_scheduler.sv
// Per-frame update scheduler: opens a grant window at vblank, aborts it at the next frame start.
// Optional per-grant watchdog is built when SCHED_WATCHDOG_EN is defined.
module vga_frame_scheduler
    import vga_timing_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int FRAME_CNT_W = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   p_tick,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   overrun_clr,
    vga_frame_scheduler_if.slave   bus,
    output logic                   frame_tick,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_REQ);

    sched_state_t state_q, state_d;
    logic [NUM_REQ-1:0]     pending_q, pending_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_tick_q, frame_tick_d;
    logic                   overrun_q, overrun_d;

    logic               vblank_start, frame_start;
    logic               scan_end, cur_pending, done_hit, wdog_hit, release_grant;
    logic [NUM_REQ-1:0] idx_onehot;
    logic [NUM_REQ-1:0] pending_shift;

    vga_frame_events #(.V_DISPLAY(V_DISPLAY)) u_events (
        .p_tick       (p_tick),
        .x            (x),
        .y            (y),
        .vblank_start (vblank_start),
        .frame_start  (frame_start)
    );

    // Shifts instead of variable bit-selects keep idx == NUM_REQ in range.
    assign scan_end      = (idx_q == IDX_END);
    assign pending_shift = pending_q >> idx_q;
    assign cur_pending   = !scan_end && pending_shift[0];
    assign idx_onehot    = NUM_REQ'(1) << idx_q;
    assign done_hit      = (state_q == GRANT) && |(bus.done & grant_q);
    assign release_grant = done_hit || wdog_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            grant_q      <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (vblank_start) state_d = SCAN;
            end
            SCAN: begin
                if (frame_start)      state_d = IDLE;
                else if (scan_end)    state_d = IDLE;
                else if (cur_pending) state_d = GRANT;
            end
            GRANT: begin
                if (frame_start)        state_d = IDLE;
                else if (release_grant) state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d    = pending_q;
        grant_d      = grant_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        frame_tick_d = 1'b0;
        overrun_d    = overrun_q & ~overrun_clr;
        unique case (state_q)
            IDLE: begin
                if (vblank_start) begin
                    frame_tick_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                    pending_d    = bus.req;
                    idx_d        = '0;
                    grant_d      = '0;
                end
            end
            SCAN: begin
                if (cur_pending)    grant_d = idx_onehot;
                else if (!scan_end) idx_d   = idx_q + 1'b1;
            end
            GRANT: begin
                if (release_grant) begin
                    grant_d   = '0;
                    pending_d = pending_q & ~idx_onehot;
                    idx_d     = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Frame start with the window still open overrides everything above.
        if ((state_q != IDLE) && frame_start) begin
            grant_d   = '0;
            pending_d = '0;
            overrun_d = 1'b1;
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [NUM_REQ-1:0] timeout_q, timeout_d;

    assign wdog_hit = (state_q == GRANT) && (wdog_q == '0) && !done_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= '0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // Down-counter reloaded on every entry to GRANT; terminal count is zero.
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if ((state_q == SCAN) && cur_pending)
            wdog_d = WDOG_LOAD;
        else if ((state_q == GRANT) && (wdog_q != '0))
            wdog_d = wdog_q - 1'b1;
        if (wdog_hit && !frame_start)
            timeout_d = timeout_q | idx_onehot;
    end

    assign bus.timeout = timeout_q;
`else
    assign wdog_hit    = 1'b0;
    assign bus.timeout = '0;
`endif

    assign bus.grant  = grant_q;
    assign frame_tick = frame_tick_q;
    assign busy       = (state_q != IDLE);
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler with a grant-order scoreboard.
module tb_vga_frame_scheduler;
    localparam int NUM_REQ     = 4;
    localparam int V_DISP      = 480;
    localparam int FCW         = 3;
    localparam int WDOG        = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           p_tick = 1'b0;
    logic [9:0]     x = 10'd5;
    logic [9:0]     y = 10'd100;
    logic           overrun_clr = 1'b0;
    logic           frame_tick, busy, overrun;
    logic [FCW-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [NUM_REQ-1:0] exp_q[$];
    logic [NUM_REQ-1:0] prev_g = '0;

    vga_frame_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    vga_frame_scheduler #(
        .NUM_REQ(NUM_REQ), .V_DISPLAY(V_DISP), .FRAME_CNT_W(FCW), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
        .overrun_clr(overrun_clr), .bus(bus), .frame_tick(frame_tick),
        .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vblank();
        p_tick = 1'b1; x = 10'd0; y = 10'(V_DISP);
        step();
        p_tick = 1'b0; x = 10'd5; y = 10'(V_DISP + 1);
        exp_cnt = (exp_cnt + 1) % (1 << FCW);
    endtask

    task automatic frame_start_ev(input logic clr);
        p_tick = 1'b1; x = 10'd0; y = 10'd0; overrun_clr = clr;
        step();
        p_tick = 1'b0; x = 10'd5; y = 10'd1; overrun_clr = 1'b0;
    endtask

    task automatic wait_grant();
        int k = 0;
        while (bus.grant == '0 && k < 50) begin step(); k++; end
        chk("grant_wait", 32'(bus.grant != '0), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin step(); k++; end
        chk("idle_wait", 32'(busy), 0);
    endtask

    task automatic serve(input int n);
        logic [NUM_REQ-1:0] g;
        for (int i = 0; i < n; i++) begin
            wait_grant();
            g = bus.grant;
            repeat (3) step();
            bus.done = g;
            step();
            bus.done = '0;
            chk("grant_drop", 32'(bus.grant), 0);
        end
    endtask

    // Scoreboard: each new non-zero grant must match the next expected grant.
    always @(negedge clk) begin
        if (bus.grant != '0 && bus.grant != prev_g) begin
            if (exp_q.size() == 0) chk("unexpected_grant", 32'(bus.grant), 0);
            else chk("grant_order", 32'(bus.grant), 32'(exp_q.pop_front()));
        end
        if (!$onehot0(bus.grant)) chk("grant_onehot", 32'(bus.grant), 0);
        prev_g = bus.grant;
    end

    initial begin
        int n;
        bus.req = '0;
        bus.done = '0;
        repeat (3) step();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        reset = 1'b0;
        step();

        // Test 1: three grants in index order.
        bus.req = 4'b1011;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
        vblank();
        chk("t1_tick", 32'(frame_tick), 1);
        chk("t1_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("t1_busy", 32'(busy), 1);
        step();
        chk("t1_tick_pulse", 32'(frame_tick), 0);
        serve(3);
        wait_idle();
        chk("t1_queue", 32'(exp_q.size()), 0);

        // Test 2: empty request set walks the full scan.
        bus.req = '0;
        vblank();
        chk("t2_tick", 32'(frame_tick), 1);
        n = 0;
        while (busy && n < 20) begin n++; step(); end
        chk("t2_busy_len", 32'(n), NUM_REQ + 1);
        chk("t2_grant", 32'(bus.grant), 0);
        chk("t2_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Test 3: abort at frame start, then clear.
        bus.req = 4'b0010;
        exp_q.push_back(4'b0010);
        vblank();
        wait_grant();
        repeat (4) step();
        frame_start_ev(1'b0);
        chk("t3_grant", 32'(bus.grant), 0);
        chk("t3_overrun", 32'(overrun), 1);
        chk("t3_busy", 32'(busy), 0);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("t3_clr", 32'(overrun), 0);

        // Test 4: set beats clear in the same cycle.
        bus.req = 4'b0001;
        exp_q.push_back(4'b0001);
        vblank();
        wait_grant();
        frame_start_ev(1'b1);
        chk("t4_overrun", 32'(overrun), 1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("t4_clr", 32'(overrun), 0);

        // Test 5: foreign done and late req changes are ignored.
        bus.req = 4'b0101;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0100);
        vblank();
        wait_grant();
        bus.req = '0;
        bus.done = 4'b0100;
        repeat (2) step();
        chk("t5_hold_a", 32'(bus.grant), 32'h1);
        bus.req = 4'b1111;
        bus.done = 4'b0010;
        step();
        bus.done = '0;
        chk("t5_hold_b", 32'(bus.grant), 32'h1);
        serve(2);
        wait_idle();
        chk("t5_queue", 32'(exp_q.size()), 0);
        bus.req = '0;

        // Frame counter wraps at its width.
        for (int f = 0; f < 3; f++) begin
            vblank();
            chk("wrap_cnt", 32'(frame_cnt), 32'(exp_cnt));
            wait_idle();
        end
        chk("wrap_zero", 32'(frame_cnt), 0);

        // Test 6: withheld done.
`ifdef SCHED_WATCHDOG_EN
        bus.req = 4'b0011;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        vblank();
        wait_grant();
        n = 0;
        while (bus.grant == 4'b0001 && n < 40) begin n++; step(); end
        chk("t6_wdog_len", 32'(n), WDOG);
        chk("t6_timeout", 32'(bus.timeout), 32'h1);
        serve(1);
        wait_idle();
        chk("t6_timeout_sticky", 32'(bus.timeout), 32'h1);
`else
        bus.req = 4'b0001;
        exp_q.push_back(4'b0001);
        vblank();
        wait_grant();
        repeat (40) step();
        chk("t6_hold", 32'(bus.grant), 32'h1);
        chk("t6_timeout", 32'(bus.timeout), 0);
        frame_start_ev(1'b0);
        chk("t6_abort", 32'(overrun), 1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
`endif

        // Reset mid-grant.
        bus.req = 4'b0100;
        exp_q.push_back(4'b0100);
        vblank();
        wait_grant();
        reset = 1'b1;
        step();
        chk("rst_mid_grant", 32'(bus.grant), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_cnt", 32'(frame_cnt), 0);
        chk("rst_mid_timeout", 32'(bus.timeout), 0);
        reset = 1'b0;
        step();
        chk("final_queue", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
